// File: rtl/result_readback.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : result_readback                                                |
// | Purpose : captures multiplier write-backs into a FIFO and streams them   |
// |           to the host (first-word-fall-through) once the run is done.    |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module result_readback #(
  parameter int DW    = 32,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          done,
  input  logic          we,
  input  logic [DW-1:0] c,
  input  logic          we_ov,
  input  logic          overflow,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_ov,
  output logic [AW-1:0] out_idx,
  output logic [AW:0]   count,
  output logic          lost,
  output logic          busy,
  output logic          drained
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DRAIN   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);

  state_t        r_state;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_lost;
  logic [DW:0]   r_mem [DEPTH];

  logic          w_push_req;
  logic          w_pop;
  logic          w_push;
  logic          w_full;
  logic [DW:0]   w_head;

  assign w_head     = r_mem[r_rd_ptr];
  assign w_full     = (r_count == c_depth);
  assign out_valid  = (r_state == S_DRAIN) && (r_count != '0);
  assign w_pop      = out_valid && out_ready;
  assign w_push_req = we && ((r_state == S_COLLECT) || (r_state == S_DRAIN));
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign w_push     = w_push_req && (!w_full || w_pop);

  assign out_data = w_head[DW-1:0];
  assign out_ov   = w_head[DW];
  assign out_idx  = r_rd_ptr;
  assign count    = r_count;
  assign lost     = r_lost;
  assign busy     = (r_state != S_IDLE);
  assign drained  = (r_state == S_DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_lost   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= {we_ov & overflow, c};
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push_req && !w_push) begin
        r_lost <= 1'b1;
      end
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);

      case (r_state)
        S_IDLE: begin
          // No push or pop can happen in IDLE, so clearing here never races them.
          if (start) begin
            r_state  <= S_COLLECT;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_lost   <= 1'b0;
          end
        end
        S_COLLECT: begin
          if (done) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if ((r_count == '0) && !w_push) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_result_readback.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_result_readback                                             |
// | Purpose : directed bench for result_readback with a queue-based model.  |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_result_readback;

  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          done = 1'b0;
  logic          we = 1'b0;
  logic [DW-1:0] c = '0;
  logic          we_ov = 1'b0;
  logic          overflow = 1'b0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ov;
  logic [AW-1:0] out_idx;
  logic [AW:0]   count;
  logic          lost;
  logic          busy;
  logic          drained;

  result_readback #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .done(done), .we(we), .c(c),
    .we_ov(we_ov), .overflow(overflow), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_ov(out_ov),
    .out_idx(out_idx), .count(count), .lost(lost), .busy(busy),
    .drained(drained)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: phase 0 idle, 1 collecting, 2 draining, 3 done; FIFO as a queue.
  int          m_phase = 0;
  logic [DW:0] m_q[$];
  int          m_rd = 0;
  bit          m_lost = 1'b0;
  bit          m_valid;
  bit          m_pop;
  bit          m_push_req;
  int          m_sz;
  int          drained_seen = 0;
  logic [DW:0] log_e[$];
  int          log_idx[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      m_phase = 0;
      m_q.delete();
      m_rd = 0;
      m_lost = 1'b0;
    end
    m_valid = (m_phase == 2) && (m_q.size() != 0);
    chk("out_valid", out_valid, m_valid);
    chk("count", count, m_q.size());
    chk("lost", lost, m_lost);
    chk("busy", busy, m_phase != 0);
    chk("drained", drained, m_phase == 3);
    chk("out_idx", out_idx, m_rd);
    if (!reset) begin
      chk("rst_out_data", out_data, 0);
      chk("rst_out_ov", out_ov, 0);
    end else if (m_valid) begin
      chk("out_data", out_data, m_q[0][DW-1:0]);
      chk("out_ov", out_ov, m_q[0][DW]);
    end
    if (drained === 1'b1) drained_seen++;
    if (reset) begin
      if (out_valid && out_ready) begin
        log_e.push_back({out_ov, out_data});
        log_idx.push_back(int'(out_idx));
      end
      m_sz       = m_q.size();
      m_pop      = m_valid && out_ready;
      m_push_req = we && (m_phase == 1 || m_phase == 2);
      case (m_phase)
        0: if (start) begin
          m_phase = 1;
          m_q.delete();
          m_rd = 0;
          m_lost = 1'b0;
        end
        1, 2: begin
          if (m_pop) begin
            void'(m_q.pop_front());
            m_rd = (m_rd + 1) % DEPTH;
          end
          if (m_push_req) begin
            if (m_sz < DEPTH || m_pop) m_q.push_back({we_ov & overflow, c});
            else m_lost = 1'b1;
          end
          if (m_phase == 1) begin
            if (done) m_phase = 2;
          end else if (m_sz == 0 && !m_push_req) begin
            m_phase = 3;
          end
        end
        default: m_phase = 0;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [DW-1:0] d, input logic ovf, input logic wov);
    we = 1'b1; c = d; overflow = ovf; we_ov = wov;
    tick();
    we = 1'b0; we_ov = 1'b0; overflow = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic pulse_done();
    done = 1'b1; tick(); done = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n;
    out_ready = 1'b1;
    n = 0;
    while (drained !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk(name, drained, 1);
    tick();
    out_ready = 1'b0;
  endtask

  int d0;

  initial begin
    // T1: reset held with random inputs.
    repeat (5) begin
      start = 1'($urandom_range(0, 1)); done = 1'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1)); c = $urandom();
      we_ov = 1'($urandom_range(0, 1)); overflow = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    start = 0; done = 0; we = 0; c = '0; we_ov = 0; overflow = 0; out_ready = 0;
    reset = 1'b1;
    tick();
    chk("t1_busy_idle", busy, 0);
    chk("t1_count_idle", count, 0);
    pulse_start();
    chk("t1_busy_after_start", busy, 1);

    // T2: basic three-entry run.
    log_e.delete(); log_idx.delete();
    write(32'h3F800000, 1'b0, 1'b0);
    write(32'h40000000, 1'b0, 1'b0);
    write(32'h7F800000, 1'b1, 1'b1);
    pulse_done();
    d0 = drained_seen;
    wait_drain(20, "t2_drained");
    chk("t2_pulses", drained_seen - d0, 1);
    chk("t2_len", log_e.size(), 3);
    if (log_e.size() == 3) begin
      chk("t2_e0", log_e[0], {1'b0, 32'h3F800000});
      chk("t2_e1", log_e[1], {1'b0, 32'h40000000});
      chk("t2_e2", log_e[2], {1'b1, 32'h7F800000});
      chk("t2_i0", log_idx[0], 0);
      chk("t2_i1", log_idx[1], 1);
      chk("t2_i2", log_idx[2], 2);
    end

    // T3: overfill by one.
    log_e.delete(); log_idx.delete();
    pulse_start();
    for (int i = 0; i < 9; i++) write(32'h100 + i, 1'b0, 1'b0);
    chk("t3_count", count, 8);
    chk("t3_lost", lost, 1);
    pulse_done();
    wait_drain(30, "t3_drained");
    chk("t3_len", log_e.size(), 8);
    for (int i = 0; i < 8 && i < log_e.size(); i++) chk("t3_val", log_e[i], 33'h100 + i);

    // T4: backpressure then alternating ready.
    log_e.delete(); log_idx.delete();
    pulse_start();
    for (int i = 0; i < 4; i++) write(32'h200 + i, 1'b0, 1'b0);
    pulse_done();
    out_ready = 1'b0;
    repeat (5) begin
      tick();
      chk("t4_hold_valid", out_valid, 1);
      chk("t4_hold_data", out_data, 32'h200);
    end
    for (int k = 0; k < 8; k++) begin
      out_ready = (k % 2 == 0);
      tick();
    end
    chk("t4_len", log_e.size(), 4);
    for (int i = 0; i < 4 && i < log_e.size(); i++) chk("t4_val", log_e[i], 33'h200 + i);
    wait_drain(20, "t4_drained");

    // T5: simultaneous push and pop while full.
    log_e.delete(); log_idx.delete();
    pulse_start();
    for (int i = 0; i < 8; i++) write(32'h300 + i, 1'b0, 1'b0);
    pulse_done();
    for (int i = 0; i < 10; i++) begin
      we = 1'b1; c = 32'h400 + i; out_ready = 1'b1;
      tick();
      chk("t5_count", count, 8);
      chk("t5_lost", lost, 0);
    end
    we = 1'b0;
    wait_drain(40, "t5_drained");
    chk("t5_len", log_e.size(), 18);
    for (int i = 0; i < 18 && i < log_e.size(); i++) begin
      chk("t5_val", log_e[i], (i < 8) ? (33'h300 + i) : (33'h400 + i - 8));
      chk("t5_idx", log_idx[i], i % 8);
    end

    // T6: stray controls, then reset in the middle of a drain.
    pulse_start();
    write(32'h500, 1'b0, 1'b0);
    write(32'h501, 1'b0, 1'b0);
    pulse_start();
    write(32'h502, 1'b0, 1'b0);
    write(32'h503, 1'b0, 1'b0);
    chk("t6_count_collect", count, 4);
    pulse_done();
    out_ready = 1'b0;
    pulse_done();
    pulse_start();
    chk("t6_count_drain", count, 4);
    chk("t6_valid_drain", out_valid, 1);
    d0 = drained_seen;
    reset = 1'b0;
    #1;
    chk("t6_rst_count", count, 0);
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_busy", busy, 0);
    tick();
    tick();
    reset = 1'b1;
    repeat (3) tick();
    chk("t6_no_pulse", drained_seen - d0, 0);
    chk("t6_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
